// File: rtl/ob_cmd_arb_pkg.sv
// Shared types and build-time defaults for the order-book command arbiter.
// Holds the command word layout, arbiter id/state types and default sizing.
package ob_cmd_arb_pkg;

    localparam int CMD_ARB_N_REQ     = 4;
    localparam int CMD_ARB_BURST_MAX = 4;

    typedef logic [$clog2(CMD_ARB_N_REQ)-1:0] arb_id_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [1:0]  opcode;
        logic        side;
        logic [15:0] order_id;
        logic [15:0] price;
        logic [11:0] qty;
    } cmd_t;

endpackage

// File: rtl/ob_cmd_arb_if.sv
// Requester-side and order-book-side handshake bundle of the command arbiter.
// master = arbiter, slave = the environment driving requests and backpressure.
interface ob_cmd_arb_if
    import ob_cmd_arb_pkg::*;
#(
    parameter int N_REQ = CMD_ARB_N_REQ
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_vld;
    cmd_t [N_REQ-1:0]       req_cmd;
    logic [N_REQ-1:0]       req_ack;
    logic                   cmd_vld_r;
    cmd_t                   cmd_r;
    logic                   cmd_full_r;
    logic [ID_W-1:0]        grant_id_r;
    logic                   busy_r;

    modport master (
        input  req_vld, req_cmd, cmd_full_r,
        output req_ack, cmd_vld_r, cmd_r, grant_id_r, busy_r
    );

    modport slave (
        output req_vld, req_cmd, cmd_full_r,
        input  req_ack, cmd_vld_r, cmd_r, grant_id_r, busy_r
    );

endinterface

// File: rtl/ob_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr,
// wrapping modulo N_REQ. Returns one-hot grant, encoded id and an any flag.
module ob_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] id,
    output logic                     any
);
    localparam int ID_W = $clog2(N_REQ);

    // Explicit compare so non-power-of-2 N_REQ wraps correctly.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    logic [ID_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        id   = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = wrap_add(ptr, i);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                id        = cand;
            end
        end
    end

endmodule

// File: rtl/ob_cmd_arb.sv
// Round-robin, burst-bounded arbiter feeding the single order-book command port.
// Optional per-requester issue and stall counters under OB_CMD_ARB_STATS_EN.
module ob_cmd_arb
    import ob_cmd_arb_pkg::*;
#(
    parameter int N_REQ     = CMD_ARB_N_REQ,
    parameter int BURST_MAX = CMD_ARB_BURST_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    ob_cmd_arb_if.master          bus
`ifdef OB_CMD_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][31:0] stat_issue_r,
    output logic [31:0]            stat_stall_r
`endif
);
    localparam int         ID_W       = $clog2(N_REQ);
    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX);

    function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
        if (int'(p) == N_REQ - 1) return '0;
        return p + 1'b1;
    endfunction

    arb_state_t       state, state_nxt;
    logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]  lock, lock_nxt;
    logic [3:0]       burst_cnt, burst_cnt_nxt;
    logic [ID_W-1:0]  sel;
    logic             sel_vld;
    logic             issue;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] lock_oh;
    logic [N_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]  pick_id;
    logic             pick_any;

    ob_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (bus.req_vld),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .id  (pick_id),
        .any (pick_any)
    );

    assign lock_oh     = N_REQ'(1) << lock;
    assign bus.req_ack = ack;

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        lock_nxt      = lock;
        burst_cnt_nxt = burst_cnt;
        sel           = pick_id;
        sel_vld       = pick_any;
        ack           = '0;

        if (state == BURST) begin
            sel     = lock;
            sel_vld = bus.req_vld[lock];
        end
        issue = sel_vld & ~bus.cmd_full_r;
        if (issue) ack = (state == BURST) ? lock_oh : pick_gnt;

        case (state)
            IDLE: begin
                if (issue) begin
                    burst_cnt_nxt = 4'd1;
                    if (BURST_MAX > 1) begin
                        state_nxt = BURST;
                        lock_nxt  = sel;
                    end else begin
                        rr_ptr_nxt = ptr_inc(sel);
                    end
                end
            end
            BURST: begin
                // A dropped lock costs one bubble; the pick restarts next cycle.
                if (!sel_vld) begin
                    rr_ptr_nxt = ptr_inc(lock);
                    state_nxt  = IDLE;
                end else if (issue) begin
                    burst_cnt_nxt = burst_cnt + 4'd1;
                    if (burst_cnt_nxt == BURST_LAST) begin
                        rr_ptr_nxt = ptr_inc(lock);
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lock       <= '0;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            lock       <= lock_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

    // Output register stage: one cycle from req_ack to cmd_vld_r.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.cmd_vld_r  <= 1'b0;
            bus.cmd_r      <= '0;
            bus.grant_id_r <= '0;
            bus.busy_r     <= 1'b0;
        end else begin
            bus.cmd_vld_r <= issue;
            bus.busy_r    <= (state_nxt == BURST);
            if (issue) begin
                bus.cmd_r      <= bus.req_cmd[sel];
                bus.grant_id_r <= sel;
            end
        end
    end

`ifdef OB_CMD_ARB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_issue_r <= '0;
            stat_stall_r <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (ack[i]) stat_issue_r[i] <= sat_inc(stat_issue_r[i]);
            end
            if ((|bus.req_vld) && bus.cmd_full_r) stat_stall_r <= sat_inc(stat_stall_r);
        end
    end
`endif

endmodule

// File: tb/tb_ob_cmd_arb.sv
// Directed bench for ob_cmd_arb (N_REQ=4, BURST_MAX=4) with hand-computed
// expected acks, grants, commands and busy flags per cycle.
module tb_ob_cmd_arb;
    import ob_cmd_arb_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    cmd_t cmds [4];

    ob_cmd_arb_if #(.N_REQ(4)) bus ();

`ifdef OB_CMD_ARB_STATS_EN
    logic [3:0][31:0] stat_issue_r;
    logic [31:0]      stat_stall_r;
`endif

    ob_cmd_arb #(.N_REQ(4), .BURST_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef OB_CMD_ARB_STATS_EN
        ,
        .stat_issue_r (stat_issue_r),
        .stat_stall_r (stat_stall_r)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cmd_t mk_cmd(input int r, input int t);
        cmd_t c;
        c.opcode   = 2'(r);
        c.side     = 1'(t);
        c.order_id = 16'(t * 16 + r + 1);
        c.price    = 16'(16'h1000 + r * 3 + t);
        c.qty      = 12'(r + 7);
        return c;
    endfunction

    function automatic int oh2id(input logic [3:0] oh);
        int id;
        id = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) id = i;
        return id;
    endfunction

    task automatic load_cmds(input int t);
        for (int i = 0; i < 4; i++) begin
            cmds[i]        = mk_cmd(i, t);
            bus.req_cmd[i] = cmds[i];
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        bus.req_vld    = '0;
        bus.cmd_full_r = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One cycle: drive, check combinational ack, clock, check registered outputs.
    task automatic cyc(input logic [3:0] vld, input logic full, input logic [3:0] exp_ack,
                       input logic exp_busy);
        bus.req_vld    = vld;
        bus.cmd_full_r = full;
        #1;
        chk("req_ack", 64'(bus.req_ack), 64'(exp_ack));
        @(posedge clk);
        #1;
        chk("cmd_vld_r", 64'(bus.cmd_vld_r), 64'(exp_ack != 4'b0000));
        if (exp_ack != 4'b0000) begin
            chk("grant_id_r", 64'(bus.grant_id_r), 64'(oh2id(exp_ack)));
            chk("cmd_r", 64'(bus.cmd_r), 64'(cmds[oh2id(exp_ack)]));
        end
        chk("busy_r", 64'(bus.busy_r), 64'(exp_busy));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        load_cmds(0);
        do_reset();

        // Reset values and idle inputs.
        chk("rst_cmd_vld_r", 64'(bus.cmd_vld_r), 64'd0);
        chk("rst_cmd_r", 64'(bus.cmd_r), 64'd0);
        chk("rst_grant_id_r", 64'(bus.grant_id_r), 64'd0);
        chk("rst_busy_r", 64'(bus.busy_r), 64'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(4'b0000, 1'b0, 4'b0000, 1'b0);
            chk("idle_grant_id_r", 64'(bus.grant_id_r), 64'd0);
        end

        // Single requester: burst of 4, re-arbitrate with no bubble, then drop.
        load_cmds(1);
        cyc(4'b0001, 1'b0, 4'b0001, 1'b1);
        cyc(4'b0001, 1'b0, 4'b0001, 1'b1);
        cyc(4'b0001, 1'b0, 4'b0001, 1'b1);
        cyc(4'b0001, 1'b0, 4'b0001, 1'b0);
        cyc(4'b0001, 1'b0, 4'b0001, 1'b1);
        cyc(4'b0001, 1'b0, 4'b0001, 1'b1);
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0);

        // All requesters: grant order 0x4, 1x4, 2x4, 3x4, then 0.
        do_reset();
        load_cmds(2);
        for (int i = 0; i < 17; i++) begin
            logic [3:0] oh;
            oh = 4'b0001 << ((i / 4) % 4);
            cyc(4'b1111, 1'b0, oh, (i % 4) != 3);
        end

        // Backpressure mid-burst holds the lock and the burst count.
        do_reset();
        load_cmds(3);
        cyc(4'b0110, 1'b0, 4'b0010, 1'b1);
        cyc(4'b0110, 1'b0, 4'b0010, 1'b1);
        cyc(4'b0110, 1'b1, 4'b0000, 1'b1);
        cyc(4'b0110, 1'b1, 4'b0000, 1'b1);
        cyc(4'b0110, 1'b1, 4'b0000, 1'b1);
        cyc(4'b0110, 1'b0, 4'b0010, 1'b1);
        cyc(4'b0110, 1'b0, 4'b0010, 1'b0);
        cyc(4'b0110, 1'b0, 4'b0100, 1'b1);

        // Locked requester drops: one bubble, then req 3, pointer back to 0.
        do_reset();
        load_cmds(4);
        cyc(4'b1100, 1'b0, 4'b0100, 1'b1);
        cyc(4'b1000, 1'b0, 4'b0000, 1'b0);
        cyc(4'b1000, 1'b0, 4'b1000, 1'b1);
        cyc(4'b1000, 1'b0, 4'b1000, 1'b1);
        cyc(4'b1000, 1'b0, 4'b1000, 1'b1);
        cyc(4'b1000, 1'b0, 4'b1000, 1'b0);
        cyc(4'b1111, 1'b0, 4'b0001, 1'b1);

        // Asynchronous reset mid-burst clears outputs without a clock edge.
        do_reset();
        load_cmds(5);
        cyc(4'b0100, 1'b0, 4'b0100, 1'b1);
        cyc(4'b0100, 1'b0, 4'b0100, 1'b1);
        rst = 1'b0;
        #1;
        chk("arst_cmd_vld_r", 64'(bus.cmd_vld_r), 64'd0);
        chk("arst_busy_r", 64'(bus.busy_r), 64'd0);
        chk("arst_grant_id_r", 64'(bus.grant_id_r), 64'd0);
        chk("arst_cmd_r", 64'(bus.cmd_r), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(4'b1111, 1'b0, 4'b0001, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
